phv_vlan_joiner: RTL and testbench
==================================

PHV_VLAN_JOINER -- requirements
Module: phv_vlan_joiner

Interface
REQ-001 SHALL have parameter PHV_LEN, default 6400, meaning PHV width in bits.
REQ-002 SHALL have parameter C_VLANID_WIDTH, default 12, meaning VLAN ID width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8 (power of 2, >=4), meaning entries per FIFO.
REQ-004 SHALL have parameter AF_MARGIN, default 2, meaning minimum free slots required for ready to stay high.
REQ-005 SHALL have port axis_clk  input  1  sole clock; one clock, all logic on rising edge.
REQ-006 SHALL have port aresetn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port phv_in  input  PHV_LEN  PHV from upstream stage.
REQ-008 SHALL have port phv_in_valid  input  1  phv_in qualifier.
REQ-009 SHALL have port phv_ready_out  output  1  to upstream stage_ready_in.
REQ-010 SHALL have port vlan_in  input  C_VLANID_WIDTH  VLAN ID from upstream stage.
REQ-011 SHALL have port vlan_in_valid  input  1  vlan_in qualifier.
REQ-012 SHALL have port vlan_ready_out  output  1  to upstream vlan_out_ready.
REQ-013 SHALL have port phv_out  output  PHV_LEN  paired PHV to downstream stage.
REQ-014 SHALL have port vlan_out  output  C_VLANID_WIDTH  paired VLAN ID.
REQ-015 SHALL have port out_valid  output  1  phv_out/vlan_out valid pair.
REQ-016 SHALL have port out_ready  input  1  downstream accepts pair.
REQ-017 SHALL have port pair_cnt  output  32  pairs delivered.
REQ-018 SHALL have port ovf_err  output  2  sticky overflow flags {vlan, phv}.

Function
REQ-019 SHALL hold one FIFO for PHVs and one for VLAN IDs, each FIFO_DEPTH deep, first-word-fall-through.
REQ-020 SHALL push phv_in on any cycle with phv_in_valid=1 and the PHV FIFO not full, regardless of phv_ready_out; same rule for the VLAN FIFO.
REQ-021 SHALL drive phv_ready_out = registered (free slots > AF_MARGIN), recomputed each cycle from the next-state count; same rule for vlan_ready_out.
REQ-022 SHALL, on phv_in_valid=1 while full and no simultaneous pop, drop the word and set ovf_err[0] sticky; same rule for VLAN via ovf_err[1].
REQ-023 SHALL accept a push into a full FIFO when a pop occurs in the same cycle, with count unchanged.
REQ-024 SHALL assert out_valid iff both FIFOs are non-empty, presenting the head entries combinationally from storage.
REQ-025 SHALL pop both FIFOs together on out_valid=1 and out_ready=1, never one alone.
REQ-026 SHALL give a latency of one cycle: a push at edge N into empty FIFOs with the partner present makes out_valid=1 after edge N.
REQ-027 SHALL hold phv_out/vlan_out stable while out_valid=1 and out_ready=0.
REQ-028 SHALL increment pair_cnt by 1 per pop, wrapping from 0xFFFFFFFF to 0.
REQ-029 SHALL use pointers of log2(FIFO_DEPTH) bits that wrap naturally, and counts of log2(FIFO_DEPTH)+1 bits.

Reset
REQ-030 SHALL, on aresetn=0 at any time including mid-transfer, clear pointers, counts, pair_cnt and ovf_err immediately, flushing all buffered entries.
REQ-031 SHALL have reset output values out_valid=0, phv_ready_out=1, vlan_ready_out=1, pair_cnt=0, ovf_err=0; phv_out/vlan_out don't-care while out_valid=0.
REQ-032 SHALL ignore inputs during reset and accept pushes from the first edge after deassertion.

Structure
REQ-033 SHALL place default PHV_LEN and C_VLANID_WIDTH constants in the shared RMT package used by the stages.
REQ-034 SHALL instantiate one generic sub-module, sync_fwft_fifo (parameters WIDTH, DEPTH, AF_MARGIN), twice; the top holds join, pop, counter and error logic.
REQ-035 SHALL infer PHV storage as block RAM-friendly registered array, without reset on the data array.

Verification
REQ-036 SHALL cover pairing: PHV 0xA5.. at cycle 1, VLAN 0x123 at cycle 4, out_ready=1 -> out_valid first high after edge 4, vlan_out=0x123, pair_cnt=1.
REQ-037 SHALL cover backpressure: out_ready=0, push 6 PHV+VLAN pairs (DEPTH=8) -> phv_ready_out=0 after the 6th push, out_valid=1 with the first PHV held, no ovf_err.
REQ-038 SHALL cover overflow: out_ready=0, push 9 PHVs ignoring ready -> 9th dropped, ovf_err=2'b01, release -> exactly 8 PHVs emerge in order.
REQ-039 SHALL cover full push+pop: fill to 8, assert out_ready and push in the same cycle -> count stays 8, ovf_err=0, order preserved.
REQ-040 SHALL cover mid-operation reset: 3 pairs buffered, pulse aresetn low asynchronously -> out_valid=0, pair_cnt=0 and ready outputs high immediately; next pair out after 1 cycle.
REQ-041 SHALL cover wrap: preload pair_cnt to 0xFFFFFFFF via 2^32-equivalent force, one pop -> pair_cnt=0.

Source files
------------

// File: rtl/phv_vlan_joiner_pkg.sv
// Shared constants for the RMT pipeline stages.
// Holds the default PHV and VLAN ID widths used by every stage, plus the
// default buffering parameters of the PHV/VLAN joiner.
package phv_vlan_joiner_pkg;

    localparam int unsigned C_PHV_LEN_DEF      = 6400;
    localparam int unsigned C_VLANID_WIDTH_DEF = 12;
    localparam int unsigned C_FIFO_DEPTH_DEF   = 8;
    localparam int unsigned C_AF_MARGIN_DEF    = 2;

    // Sticky overflow flags, packed as {vlan, phv}.
    typedef struct packed {
        logic vlan;
        logic phv;
    } ovf_flags_t;

endpackage

// File: rtl/phv_vlan_joiner_sync_fwft_fifo.sv
// sync_fwft_fifo: single-clock first-word-fall-through FIFO.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i/wdata_i  write request and data (accepted when not full, or when
//                   a pop happens in the same cycle)
//   pop_i           read request (ignored while empty)
//   rdata_o         head entry, read combinationally from storage
//   empty_o         no entries stored
//   ready_o         registered "free slots > AF_MARGIN"
//   drop_o          this cycle's push was discarded (full, no pop)
module sync_fwft_fifo
    import phv_vlan_joiner_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = C_FIFO_DEPTH_DEF,
    parameter int unsigned AF_MARGIN = C_AF_MARGIN_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             ready_o,
    output logic             drop_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   MARGIN_C = (AW+1)'(AF_MARGIN);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Data array carries no reset so it can map onto RAM.
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          ready_q,  ready_d;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == DEPTH_C);
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign do_push = push_i && (!full || do_pop);
    assign drop_o  = push_i && full && !do_pop;
    assign rdata_o = mem_q[rd_ptr_q];
    assign ready_o = ready_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        // Ready looks at the count after this edge so it tracks occupancy
        // with a single register stage.
        ready_d = ((DEPTH_C - count_d) > MARGIN_C);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/phv_vlan_joiner.sv
// phv_vlan_joiner: pairs PHVs and VLAN IDs arriving independently from the
// upstream stage and delivers them together downstream.
// Ports:
//   axis_clk, aresetn              clock, asynchronous active-low reset
//   phv_in/phv_in_valid            PHV input, phv_ready_out = almost-full hint
//   vlan_in/vlan_in_valid          VLAN input, vlan_ready_out = almost-full hint
//   phv_out/vlan_out/out_valid     paired output, out_ready from downstream
//   pair_cnt                       pairs delivered (wrapping)
//   ovf_err                        sticky {vlan, phv} overflow flags
//
// Handshake: inputs are pushed whenever *_valid=1 and the FIFO has room; the
// ready outputs are advisory and do not gate the push. A pair transfers on
// every cycle with out_valid=1 and out_ready=1; out_valid never drops and
// the outputs never change until that transfer happens.
module phv_vlan_joiner
    import phv_vlan_joiner_pkg::*;
#(
    parameter int unsigned PHV_LEN        = C_PHV_LEN_DEF,
    parameter int unsigned C_VLANID_WIDTH = C_VLANID_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH     = C_FIFO_DEPTH_DEF,
    parameter int unsigned AF_MARGIN      = C_AF_MARGIN_DEF
) (
    input  logic                      axis_clk,
    input  logic                      aresetn,
    input  logic [PHV_LEN-1:0]        phv_in,
    input  logic                      phv_in_valid,
    output logic                      phv_ready_out,
    input  logic [C_VLANID_WIDTH-1:0] vlan_in,
    input  logic                      vlan_in_valid,
    output logic                      vlan_ready_out,
    output logic [PHV_LEN-1:0]        phv_out,
    output logic [C_VLANID_WIDTH-1:0] vlan_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               pair_cnt,
    output logic [1:0]                ovf_err
);

    logic       phv_empty, vlan_empty;
    logic       phv_drop, vlan_drop;
    logic       pop;

    logic [31:0] pair_cnt_q, pair_cnt_d;
    ovf_flags_t  ovf_err_q,  ovf_err_d;

    assign out_valid = !phv_empty && !vlan_empty;
    // Both FIFOs leave together so the pairing can never slip.
    assign pop       = out_valid && out_ready;

    sync_fwft_fifo #(
        .WIDTH     (PHV_LEN),
        .DEPTH     (FIFO_DEPTH),
        .AF_MARGIN (AF_MARGIN)
    ) u_phv_fifo (
        .clk_i   (axis_clk),
        .rst_ni  (aresetn),
        .push_i  (phv_in_valid),
        .wdata_i (phv_in),
        .pop_i   (pop),
        .rdata_o (phv_out),
        .empty_o (phv_empty),
        .ready_o (phv_ready_out),
        .drop_o  (phv_drop)
    );

    sync_fwft_fifo #(
        .WIDTH     (C_VLANID_WIDTH),
        .DEPTH     (FIFO_DEPTH),
        .AF_MARGIN (AF_MARGIN)
    ) u_vlan_fifo (
        .clk_i   (axis_clk),
        .rst_ni  (aresetn),
        .push_i  (vlan_in_valid),
        .wdata_i (vlan_in),
        .pop_i   (pop),
        .rdata_o (vlan_out),
        .empty_o (vlan_empty),
        .ready_o (vlan_ready_out),
        .drop_o  (vlan_drop)
    );

    always_comb begin
        pair_cnt_d     = pair_cnt_q;
        ovf_err_d      = ovf_err_q;
        if (pop) pair_cnt_d = pair_cnt_q + 32'd1;
        ovf_err_d.phv  = ovf_err_q.phv  | phv_drop;
        ovf_err_d.vlan = ovf_err_q.vlan | vlan_drop;
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            pair_cnt_q <= '0;
            ovf_err_q  <= '0;
        end else begin
            pair_cnt_q <= pair_cnt_d;
            ovf_err_q  <= ovf_err_d;
        end
    end

    assign pair_cnt = pair_cnt_q;
    assign ovf_err  = ovf_err_q;

endmodule

// File: tb/tb_phv_vlan_joiner.sv
// Testbench for phv_vlan_joiner: directed scenarios plus a randomized phase,
// all checked every cycle against a queue-based reference model.
module tb_phv_vlan_joiner;

    localparam int unsigned PW = 64;
    localparam int unsigned VW = 12;
    localparam int unsigned D  = 8;
    localparam int unsigned M  = 2;

    logic          axis_clk = 1'b0;
    logic          aresetn  = 1'b0;
    logic [PW-1:0] phv_in = '0;
    logic          phv_in_valid = 1'b0;
    logic          phv_ready_out;
    logic [VW-1:0] vlan_in = '0;
    logic          vlan_in_valid = 1'b0;
    logic          vlan_ready_out;
    logic [PW-1:0] phv_out;
    logic [VW-1:0] vlan_out;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   pair_cnt;
    logic [1:0]    ovf_err;

    phv_vlan_joiner #(
        .PHV_LEN        (PW),
        .C_VLANID_WIDTH (VW),
        .FIFO_DEPTH     (D),
        .AF_MARGIN      (M)
    ) dut (
        .axis_clk       (axis_clk),
        .aresetn        (aresetn),
        .phv_in         (phv_in),
        .phv_in_valid   (phv_in_valid),
        .phv_ready_out  (phv_ready_out),
        .vlan_in        (vlan_in),
        .vlan_in_valid  (vlan_in_valid),
        .vlan_ready_out (vlan_ready_out),
        .phv_out        (phv_out),
        .vlan_out       (vlan_out),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .pair_cnt       (pair_cnt),
        .ovf_err        (ovf_err)
    );

    // Clock / reset block
    always #5 axis_clk = ~axis_clk;

    // Scoreboard: expected FIFO contents and expected status
    logic [PW-1:0] exp_phv_q[$];
    logic [VW-1:0] exp_vlan_q[$];
    logic [31:0]   exp_pairs;
    logic [1:0]    exp_ovf;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_phv_q.delete();
        exp_vlan_q.delete();
        exp_pairs = '0;
        exp_ovf   = '0;
    endtask

    // Compare every output against the scoreboard.
    task automatic check_all(input string tag);
        logic exp_v;
        exp_v = (exp_phv_q.size() > 0) && (exp_vlan_q.size() > 0);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(exp_v));
        if (exp_v) begin
            check({tag, ".phv_out"},  64'(phv_out),  64'(exp_phv_q[0]));
            check({tag, ".vlan_out"}, 64'(vlan_out), 64'(exp_vlan_q[0]));
        end
        check({tag, ".phv_ready"},  64'(phv_ready_out),
              64'((int'(D) - exp_phv_q.size()) > int'(M)));
        check({tag, ".vlan_ready"}, 64'(vlan_ready_out),
              64'((int'(D) - exp_vlan_q.size()) > int'(M)));
        check({tag, ".pair_cnt"}, 64'(pair_cnt), 64'(exp_pairs));
        check({tag, ".ovf_err"},  64'(ovf_err),  64'(exp_ovf));
    endtask

    // Driver: apply one cycle of inputs, advance the model, check outputs.
    task automatic step(input string tag, input logic pv, input logic [PW-1:0] pd,
                        input logic vv, input logic [VW-1:0] vd, input logic ordy);
        logic pop_m, pfull, vfull;
        @(negedge axis_clk);
        phv_in_valid  = pv;
        phv_in        = pd;
        vlan_in_valid = vv;
        vlan_in       = vd;
        out_ready     = ordy;
        @(posedge axis_clk);
        pop_m = ordy && (exp_phv_q.size() > 0) && (exp_vlan_q.size() > 0);
        pfull = (exp_phv_q.size() == D);
        vfull = (exp_vlan_q.size() == D);
        if (pop_m) begin
            void'(exp_phv_q.pop_front());
            void'(exp_vlan_q.pop_front());
            exp_pairs = exp_pairs + 32'd1;
        end
        if (pv) begin
            if (!pfull || pop_m) exp_phv_q.push_back(pd);
            else                 exp_ovf[0] = 1'b1;
        end
        if (vv) begin
            if (!vfull || pop_m) exp_vlan_q.push_back(vd);
            else                 exp_ovf[1] = 1'b1;
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input logic ordy);
        step(tag, 1'b0, '0, 1'b0, '0, ordy);
    endtask

    // Asynchronous reset pulse between clock edges; inputs are held active
    // across an edge during reset to show they are ignored.
    task automatic async_reset(input string tag);
        @(negedge axis_clk);
        #2;
        aresetn = 1'b0;
        #1;
        check({tag, ".rst_out_valid"},  64'(out_valid),      64'd0);
        check({tag, ".rst_pair_cnt"},   64'(pair_cnt),       64'd0);
        check({tag, ".rst_phv_ready"},  64'(phv_ready_out),  64'd1);
        check({tag, ".rst_vlan_ready"}, 64'(vlan_ready_out), 64'd1);
        check({tag, ".rst_ovf_err"},    64'(ovf_err),        64'd0);
        model_clear();
        phv_in_valid  = 1'b1;
        vlan_in_valid = 1'b1;
        phv_in        = {$urandom, $urandom};
        vlan_in       = VW'($urandom);
        out_ready     = 1'b1;
        @(negedge axis_clk);
        aresetn       = 1'b1;
        phv_in_valid  = 1'b0;
        vlan_in_valid = 1'b0;
        out_ready     = 1'b0;
    endtask

    initial begin
        logic [PW-1:0] pd;
        logic [VW-1:0] vd;
        model_clear();

        // Power-on reset
        repeat (2) @(posedge axis_clk);
        #1;
        check("por.out_valid",  64'(out_valid),      64'd0);
        check("por.phv_ready",  64'(phv_ready_out),  64'd1);
        check("por.vlan_ready", 64'(vlan_ready_out), 64'd1);
        check("por.pair_cnt",   64'(pair_cnt),       64'd0);
        check("por.ovf_err",    64'(ovf_err),        64'd0);
        @(negedge axis_clk);
        aresetn = 1'b1;

        // Pairing: PHV first, VLAN three cycles later
        step("pair.c1", 1'b1, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0, '0, 1'b1);
        idle("pair.c2", 1'b1);
        idle("pair.c3", 1'b1);
        step("pair.c4", 1'b0, '0, 1'b1, 12'h123, 1'b1);
        check("pair.valid_after_c4", 64'(out_valid), 64'd1);
        check("pair.vlan_out",       64'(vlan_out),  64'h123);
        idle("pair.c5", 1'b1);
        check("pair.cnt", 64'(pair_cnt), 64'd1);

        // Backpressure: 6 pairs with downstream stalled
        for (int i = 0; i < 6; i++) begin
            step("bp.push", 1'b1, {$urandom, $urandom}, 1'b1, VW'($urandom), 1'b0);
        end
        check("bp.phv_ready_low", 64'(phv_ready_out), 64'd0);
        check("bp.ovf_none",      64'(ovf_err),       64'd0);
        for (int i = 0; i < 4; i++) idle("bp.hold", 1'b0);
        for (int i = 0; i < 7; i++) idle("bp.drain", 1'b1);

        // Overflow: 9 PHVs into an 8-deep FIFO, then release with VLANs
        for (int i = 0; i < 9; i++) begin
            step("ovf.push", 1'b1, {$urandom, 32'(i)}, 1'b0, '0, 1'b0);
        end
        check("ovf.flag", 64'(ovf_err), 64'd1);
        for (int i = 0; i < 8; i++) begin
            step("ovf.release", 1'b0, '0, 1'b1, VW'(i + 16), 1'b1);
        end
        for (int i = 0; i < 3; i++) idle("ovf.drain", 1'b1);
        check("ovf.eight_out", 64'(pair_cnt), 64'(exp_pairs));

        async_reset("rst1");
        idle("rst1.post", 1'b0);

        // Full FIFOs with simultaneous push and pop
        for (int i = 0; i < 8; i++) begin
            step("full.fill", 1'b1, {$urandom, $urandom}, 1'b1, VW'($urandom), 1'b0);
        end
        step("full.pushpop", 1'b1, 64'hFEED_FACE_0000_0001, 1'b1, 12'hABC, 1'b1);
        check("full.ovf_none", 64'(ovf_err), 64'd0);
        for (int i = 0; i < 9; i++) idle("full.drain", 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            pd = {$urandom, $urandom};
            vd = VW'($urandom);
            step("rand", $urandom_range(0, 3) != 0, pd, $urandom_range(0, 3) != 0, vd,
                 $urandom_range(0, 2) == 0);
        end
        for (int i = 0; i < 10; i++) idle("rand.drain", 1'b1);

        // Mid-operation reset with 3 pairs buffered
        for (int i = 0; i < 3; i++) begin
            step("mid.fill", 1'b1, {$urandom, $urandom}, 1'b1, VW'($urandom), 1'b0);
        end
        async_reset("mid");
        step("mid.next", 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1, 12'h0F0, 1'b0);
        check("mid.next_valid", 64'(out_valid), 64'd1);
        idle("mid.pop", 1'b1);

        // pair_cnt wrap
        step("wrap.load", 1'b1, 64'h0BAD_CAFE_0000_0000, 1'b1, 12'h777, 1'b0);
        force dut.pair_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.pair_cnt_q;
        exp_pairs = 32'hFFFF_FFFF;
        idle("wrap.pop", 1'b1);
        check("wrap.zero", 64'(pair_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
